// File: rtl/l2_port_arb.sv
// rtl/l2_port_arb.sv - two-master round-robin AXI arbiter feeding the l2_cache inport
module l2_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // master 0 (instruction fetch)
  input  logic                m0_awvalid_i,
  input  logic [ADDR_W-1:0]   m0_awaddr_i,
  input  logic [ID_W-1:0]     m0_awid_i,
  input  logic [7:0]          m0_awlen_i,
  input  logic [1:0]          m0_awburst_i,
  input  logic [2:0]          m0_awsize_i,
  output logic                m0_awready_o,
  input  logic                m0_wvalid_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  input  logic                m0_wlast_i,
  output logic                m0_wready_o,
  output logic                m0_bvalid_o,
  output logic [1:0]          m0_bresp_o,
  output logic [ID_W-1:0]     m0_bid_o,
  input  logic                m0_bready_i,
  input  logic                m0_arvalid_i,
  input  logic [ADDR_W-1:0]   m0_araddr_i,
  input  logic [ID_W-1:0]     m0_arid_i,
  input  logic [7:0]          m0_arlen_i,
  input  logic [1:0]          m0_arburst_i,
  input  logic [2:0]          m0_arsize_i,
  output logic                m0_arready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic [1:0]          m0_rresp_o,
  output logic [ID_W-1:0]     m0_rid_o,
  output logic                m0_rlast_o,
  input  logic                m0_rready_i,
  // master 1 (data)
  input  logic                m1_awvalid_i,
  input  logic [ADDR_W-1:0]   m1_awaddr_i,
  input  logic [ID_W-1:0]     m1_awid_i,
  input  logic [7:0]          m1_awlen_i,
  input  logic [1:0]          m1_awburst_i,
  input  logic [2:0]          m1_awsize_i,
  output logic                m1_awready_o,
  input  logic                m1_wvalid_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  input  logic                m1_wlast_i,
  output logic                m1_wready_o,
  output logic                m1_bvalid_o,
  output logic [1:0]          m1_bresp_o,
  output logic [ID_W-1:0]     m1_bid_o,
  input  logic                m1_bready_i,
  input  logic                m1_arvalid_i,
  input  logic [ADDR_W-1:0]   m1_araddr_i,
  input  logic [ID_W-1:0]     m1_arid_i,
  input  logic [7:0]          m1_arlen_i,
  input  logic [1:0]          m1_arburst_i,
  input  logic [2:0]          m1_arsize_i,
  output logic                m1_arready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic [1:0]          m1_rresp_o,
  output logic [ID_W-1:0]     m1_rid_o,
  output logic                m1_rlast_o,
  input  logic                m1_rready_i,
  // slave side to l2_cache inport
  output logic                s_awvalid_o,
  output logic [ADDR_W-1:0]   s_awaddr_o,
  output logic [ID_W-1:0]     s_awid_o,
  output logic [7:0]          s_awlen_o,
  output logic [1:0]          s_awburst_o,
  output logic [2:0]          s_awsize_o,
  input  logic                s_awready_i,
  output logic                s_wvalid_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  output logic                s_wlast_o,
  input  logic                s_wready_i,
  input  logic                s_bvalid_i,
  input  logic [1:0]          s_bresp_i,
  input  logic [ID_W-1:0]     s_bid_i,
  output logic                s_bready_o,
  output logic                s_arvalid_o,
  output logic [ADDR_W-1:0]   s_araddr_o,
  output logic [ID_W-1:0]     s_arid_o,
  output logic [7:0]          s_arlen_o,
  output logic [1:0]          s_arburst_o,
  output logic [2:0]          s_arsize_o,
  input  logic                s_arready_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic [1:0]          s_rresp_i,
  input  logic [ID_W-1:0]     s_rid_i,
  input  logic                s_rlast_i,
  output logic                s_rready_o
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;

  state_e            state_q;
  logic              gnt_q, rr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic [2:0]        size_q;

  logic req0, req1, win, win_aw, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [ID_W-1:0]   sel_id;
  logic [7:0]        sel_len;
  logic [1:0]        sel_burst;
  logic [2:0]        sel_size;
  logic in_w, in_b, in_r;

  // A lone requester wins outright; the rr pointer only breaks ties.
  assign req0   = m0_awvalid_i | m0_arvalid_i;
  assign req1   = m1_awvalid_i | m1_arvalid_i;
  assign win    = (req0 & req1) ? rr_q : req1;
  assign win_aw = win ? m1_awvalid_i : m0_awvalid_i;
  assign grant  = rst_ni & (state_q == IDLE) & (req0 | req1);

  assign m0_awready_o = grant & ~win & m0_awvalid_i;
  assign m0_arready_o = grant & ~win & ~m0_awvalid_i & m0_arvalid_i;
  assign m1_awready_o = grant & win & m1_awvalid_i;
  assign m1_arready_o = grant & win & ~m1_awvalid_i & m1_arvalid_i;

  always_comb begin
    sel_addr  = '0;
    sel_id    = '0;
    sel_len   = '0;
    sel_burst = '0;
    sel_size  = '0;
    if (win_aw) begin
      sel_addr  = win ? m1_awaddr_i  : m0_awaddr_i;
      sel_id    = win ? m1_awid_i    : m0_awid_i;
      sel_len   = win ? m1_awlen_i   : m0_awlen_i;
      sel_burst = win ? m1_awburst_i : m0_awburst_i;
      sel_size  = win ? m1_awsize_i  : m0_awsize_i;
    end else begin
      sel_addr  = win ? m1_araddr_i  : m0_araddr_i;
      sel_id    = win ? m1_arid_i    : m0_arid_i;
      sel_len   = win ? m1_arlen_i   : m0_arlen_i;
      sel_burst = win ? m1_arburst_i : m0_arburst_i;
      sel_size  = win ? m1_arsize_i  : m0_arsize_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      size_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (grant) begin
          gnt_q   <= win;
          addr_q  <= sel_addr;
          id_q    <= sel_id;
          len_q   <= sel_len;
          burst_q <= sel_burst;
          size_q  <= sel_size;
          state_q <= win_aw ? AW : AR;
        end
        AW: if (s_awready_i) state_q <= W;
        W:  if (s_wvalid_o && s_wready_i && s_wlast_o) state_q <= B;
        B:  if (s_bvalid_i && s_bready_o) begin
          state_q <= IDLE;
          rr_q    <= ~gnt_q;
        end
        AR: if (s_arready_i) state_q <= R;
        R:  if (s_rvalid_i && s_rready_o && s_rlast_i) begin
          state_q <= IDLE;
          rr_q    <= ~gnt_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Both address channels show the latched fields; only the valid differs.
  assign s_awvalid_o = (state_q == AW);
  assign s_awaddr_o  = addr_q;
  assign s_awid_o    = {gnt_q, id_q[ID_W-2:0]};
  assign s_awlen_o   = len_q;
  assign s_awburst_o = burst_q;
  assign s_awsize_o  = size_q;
  assign s_arvalid_o = (state_q == AR);
  assign s_araddr_o  = addr_q;
  assign s_arid_o    = {gnt_q, id_q[ID_W-2:0]};
  assign s_arlen_o   = len_q;
  assign s_arburst_o = burst_q;
  assign s_arsize_o  = size_q;

  assign in_w = (state_q == W);
  assign in_b = (state_q == B);
  assign in_r = (state_q == R);

  assign s_wvalid_o  = in_w & (gnt_q ? m1_wvalid_i : m0_wvalid_i);
  assign s_wdata_o   = in_w ? (gnt_q ? m1_wdata_i : m0_wdata_i) : '0;
  assign s_wstrb_o   = in_w ? (gnt_q ? m1_wstrb_i : m0_wstrb_i) : '0;
  assign s_wlast_o   = in_w & (gnt_q ? m1_wlast_i : m0_wlast_i);
  assign m0_wready_o = in_w & ~gnt_q & s_wready_i;
  assign m1_wready_o = in_w & gnt_q & s_wready_i;

  // Responses carry the master's original ID, not the slave's tagged one.
  assign s_bready_o  = in_b & (gnt_q ? m1_bready_i : m0_bready_i);
  assign m0_bvalid_o = in_b & ~gnt_q & s_bvalid_i;
  assign m0_bresp_o  = (in_b & ~gnt_q) ? s_bresp_i : '0;
  assign m0_bid_o    = (in_b & ~gnt_q) ? id_q : '0;
  assign m1_bvalid_o = in_b & gnt_q & s_bvalid_i;
  assign m1_bresp_o  = (in_b & gnt_q) ? s_bresp_i : '0;
  assign m1_bid_o    = (in_b & gnt_q) ? id_q : '0;

  assign s_rready_o  = in_r & (gnt_q ? m1_rready_i : m0_rready_i);
  assign m0_rvalid_o = in_r & ~gnt_q & s_rvalid_i;
  assign m0_rdata_o  = (in_r & ~gnt_q) ? s_rdata_i : '0;
  assign m0_rresp_o  = (in_r & ~gnt_q) ? s_rresp_i : '0;
  assign m0_rid_o    = (in_r & ~gnt_q) ? id_q : '0;
  assign m0_rlast_o  = in_r & ~gnt_q & s_rlast_i;
  assign m1_rvalid_o = in_r & gnt_q & s_rvalid_i;
  assign m1_rdata_o  = (in_r & gnt_q) ? s_rdata_i : '0;
  assign m1_rresp_o  = (in_r & gnt_q) ? s_rresp_i : '0;
  assign m1_rid_o    = (in_r & gnt_q) ? id_q : '0;
  assign m1_rlast_o  = in_r & gnt_q & s_rlast_i;

  logic unused_ids;
  assign unused_ids = ^{s_bid_i, s_rid_i, id_q[ID_W-1]};

endmodule

// File: tb/tb_l2_port_arb.sv
// tb/tb_l2_port_arb.sv - directed self-checking bench for l2_port_arb
module tb_l2_port_arb;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic m0_awvalid_i, m0_awready_o, m0_wvalid_i, m0_wlast_i, m0_wready_o, m0_bvalid_o, m0_bready_i;
  logic m0_arvalid_i, m0_arready_o, m0_rvalid_o, m0_rlast_o, m0_rready_i;
  logic [AW-1:0] m0_awaddr_i, m0_araddr_i;
  logic [IW-1:0] m0_awid_i, m0_arid_i, m0_bid_o, m0_rid_o;
  logic [7:0] m0_awlen_i, m0_arlen_i;
  logic [1:0] m0_awburst_i, m0_arburst_i, m0_bresp_o, m0_rresp_o;
  logic [2:0] m0_awsize_i, m0_arsize_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic [DW/8-1:0] m0_wstrb_i;

  logic m1_awvalid_i, m1_awready_o, m1_wvalid_i, m1_wlast_i, m1_wready_o, m1_bvalid_o, m1_bready_i;
  logic m1_arvalid_i, m1_arready_o, m1_rvalid_o, m1_rlast_o, m1_rready_i;
  logic [AW-1:0] m1_awaddr_i, m1_araddr_i;
  logic [IW-1:0] m1_awid_i, m1_arid_i, m1_bid_o, m1_rid_o;
  logic [7:0] m1_awlen_i, m1_arlen_i;
  logic [1:0] m1_awburst_i, m1_arburst_i, m1_bresp_o, m1_rresp_o;
  logic [2:0] m1_awsize_i, m1_arsize_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic [DW/8-1:0] m1_wstrb_i;

  logic s_awvalid_o, s_awready_i, s_wvalid_o, s_wlast_o, s_wready_i, s_bvalid_i, s_bready_o;
  logic s_arvalid_o, s_arready_i, s_rvalid_i, s_rlast_i, s_rready_o;
  logic [AW-1:0] s_awaddr_o, s_araddr_o;
  logic [IW-1:0] s_awid_o, s_arid_o, s_bid_i, s_rid_i;
  logic [7:0] s_awlen_o, s_arlen_o;
  logic [1:0] s_awburst_o, s_arburst_o, s_bresp_i, s_rresp_i;
  logic [2:0] s_awsize_o, s_arsize_o;
  logic [DW-1:0] s_wdata_o, s_rdata_i;
  logic [DW/8-1:0] s_wstrb_o;

  l2_port_arb #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_awvalid_i(m0_awvalid_i), .m0_awaddr_i(m0_awaddr_i), .m0_awid_i(m0_awid_i),
    .m0_awlen_i(m0_awlen_i), .m0_awburst_i(m0_awburst_i), .m0_awsize_i(m0_awsize_i),
    .m0_awready_o(m0_awready_o), .m0_wvalid_i(m0_wvalid_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_wlast_i(m0_wlast_i), .m0_wready_o(m0_wready_o),
    .m0_bvalid_o(m0_bvalid_o), .m0_bresp_o(m0_bresp_o), .m0_bid_o(m0_bid_o), .m0_bready_i(m0_bready_i),
    .m0_arvalid_i(m0_arvalid_i), .m0_araddr_i(m0_araddr_i), .m0_arid_i(m0_arid_i),
    .m0_arlen_i(m0_arlen_i), .m0_arburst_i(m0_arburst_i), .m0_arsize_i(m0_arsize_i),
    .m0_arready_o(m0_arready_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m0_rresp_o(m0_rresp_o), .m0_rid_o(m0_rid_o), .m0_rlast_o(m0_rlast_o), .m0_rready_i(m0_rready_i),
    .m1_awvalid_i(m1_awvalid_i), .m1_awaddr_i(m1_awaddr_i), .m1_awid_i(m1_awid_i),
    .m1_awlen_i(m1_awlen_i), .m1_awburst_i(m1_awburst_i), .m1_awsize_i(m1_awsize_i),
    .m1_awready_o(m1_awready_o), .m1_wvalid_i(m1_wvalid_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_wlast_i(m1_wlast_i), .m1_wready_o(m1_wready_o),
    .m1_bvalid_o(m1_bvalid_o), .m1_bresp_o(m1_bresp_o), .m1_bid_o(m1_bid_o), .m1_bready_i(m1_bready_i),
    .m1_arvalid_i(m1_arvalid_i), .m1_araddr_i(m1_araddr_i), .m1_arid_i(m1_arid_i),
    .m1_arlen_i(m1_arlen_i), .m1_arburst_i(m1_arburst_i), .m1_arsize_i(m1_arsize_i),
    .m1_arready_o(m1_arready_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .m1_rresp_o(m1_rresp_o), .m1_rid_o(m1_rid_o), .m1_rlast_o(m1_rlast_o), .m1_rready_i(m1_rready_i),
    .s_awvalid_o(s_awvalid_o), .s_awaddr_o(s_awaddr_o), .s_awid_o(s_awid_o), .s_awlen_o(s_awlen_o),
    .s_awburst_o(s_awburst_o), .s_awsize_o(s_awsize_o), .s_awready_i(s_awready_i),
    .s_wvalid_o(s_wvalid_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
    .s_wready_i(s_wready_i), .s_bvalid_i(s_bvalid_i), .s_bresp_i(s_bresp_i), .s_bid_i(s_bid_i),
    .s_bready_o(s_bready_o), .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o), .s_arid_o(s_arid_o),
    .s_arlen_o(s_arlen_o), .s_arburst_o(s_arburst_o), .s_arsize_o(s_arsize_o), .s_arready_i(s_arready_i),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rid_i(s_rid_i),
    .s_rlast_i(s_rlast_i), .s_rready_o(s_rready_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int c0, c1;
  logic exp_m1;
  localparam logic [DW-1:0] DATA = 256'h0123456789ABCDEF_FEDCBA9876543210_FFEEDDCCBBAA9988_7766554433221100;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_awvalid_i, m0_wvalid_i, m0_wlast_i, m0_bready_i, m0_arvalid_i, m0_rready_i} = '0;
    {m1_awvalid_i, m1_wvalid_i, m1_wlast_i, m1_bready_i, m1_arvalid_i, m1_rready_i} = '0;
    {m0_awaddr_i, m0_araddr_i, m0_awid_i, m0_arid_i, m0_awlen_i, m0_arlen_i} = '0;
    {m0_awburst_i, m0_arburst_i, m0_awsize_i, m0_arsize_i, m0_wdata_i, m0_wstrb_i} = '0;
    {m1_awaddr_i, m1_araddr_i, m1_awid_i, m1_arid_i, m1_awlen_i, m1_arlen_i} = '0;
    {m1_awburst_i, m1_arburst_i, m1_awsize_i, m1_arsize_i, m1_wdata_i, m1_wstrb_i} = '0;
    {s_awready_i, s_wready_i, s_bvalid_i, s_bresp_i, s_bid_i, s_arready_i} = '0;
    {s_rvalid_i, s_rdata_i, s_rresp_i, s_rid_i, s_rlast_i} = '0;
  endtask

  task automatic aw_accept();
    s_awready_i = 1'b1; tick(); s_awready_i = 1'b0;
  endtask

  task automatic ar_accept();
    s_arready_i = 1'b1; tick(); s_arready_i = 1'b0;
  endtask

  task automatic w_beat(input logic m, input logic [DW-1:0] d);
    if (m) begin m1_wvalid_i = 1; m1_wdata_i = d; m1_wstrb_i = '1; m1_wlast_i = 1; end
    else   begin m0_wvalid_i = 1; m0_wdata_i = d; m0_wstrb_i = '1; m0_wlast_i = 1; end
    s_wready_i = 1'b1;
    tick();
    {m0_wvalid_i, m0_wlast_i, m1_wvalid_i, m1_wlast_i, s_wready_i} = '0;
  endtask

  task automatic b_done(input logic m);
    s_bvalid_i = 1'b1; s_bid_i = 4'h5;
    m0_bready_i = ~m; m1_bready_i = m;
    tick();
    {s_bvalid_i, m0_bready_i, m1_bready_i} = '0;
  endtask

  task automatic r_done(input logic m, input logic [DW-1:0] d);
    s_rvalid_i = 1'b1; s_rlast_i = 1'b1; s_rdata_i = d; s_rid_i = 4'h7;
    m0_rready_i = ~m; m1_rready_i = m;
    tick();
    {s_rvalid_i, s_rlast_i, m0_rready_i, m1_rready_i} = '0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    tick(); tick();
    // Reset state, with a request already pending
    m0_awvalid_i = 1'b1; #1;
    chk("rst_awready_gated", m0_awready_o, 0);
    chk("rst_s_awvalid", s_awvalid_o, 0);
    chk("rst_s_arvalid", s_arvalid_o, 0);
    chk("rst_s_awaddr", s_awaddr_o, 0);
    chk("rst_s_awid", s_awid_o, 0);
    chk("rst_s_wvalid", s_wvalid_o, 0);
    m0_awvalid_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // Single m0 write then read-back
    m0_awvalid_i = 1; m0_awaddr_i = 32'h1000; m0_awid_i = 4'h2; m0_awburst_i = 2'b01; m0_awsize_i = 3'd5;
    #1;
    chk("wr_m0_awready", m0_awready_o, 1);
    chk("wr_m1_awready", m1_awready_o, 0);
    tick();
    m0_awvalid_i = 0; #1;
    chk("wr_s_awvalid", s_awvalid_o, 1);
    chk("wr_s_awaddr", s_awaddr_o, 32'h1000);
    chk("wr_s_awid", s_awid_o, 4'h2);
    chk("wr_s_awsize", s_awsize_o, 3'd5);
    aw_accept();
    m0_wvalid_i = 1; m0_wdata_i = DATA; m0_wstrb_i = '1; m0_wlast_i = 1; s_wready_i = 1; #1;
    chk("wr_s_wvalid", s_wvalid_o, 1);
    chk("wr_s_wdata", s_wdata_o, DATA);
    chk("wr_m0_wready", m0_wready_o, 1);
    chk("wr_m1_wready", m1_wready_o, 0);
    tick();
    {m0_wvalid_i, m0_wlast_i, s_wready_i} = '0;
    s_bvalid_i = 1; s_bid_i = 4'h5; s_bresp_i = 2'b00; m0_bready_i = 1; #1;
    chk("wr_m0_bvalid", m0_bvalid_o, 1);
    chk("wr_m0_bid", m0_bid_o, 4'h2);
    chk("wr_m0_bresp", m0_bresp_o, 0);
    chk("wr_s_bready", s_bready_o, 1);
    tick();
    {s_bvalid_i, m0_bready_i} = '0;
    m0_arvalid_i = 1; m0_araddr_i = 32'h1000; m0_arid_i = 4'h2; #1;
    chk("rd_m0_arready_lone", m0_arready_o, 1);
    tick();
    m0_arvalid_i = 0; #1;
    chk("rd_s_arvalid", s_arvalid_o, 1);
    chk("rd_s_araddr", s_araddr_o, 32'h1000);
    chk("rd_s_arid", s_arid_o, 4'h2);
    ar_accept();
    s_rvalid_i = 1; s_rlast_i = 1; s_rdata_i = DATA; s_rid_i = 4'h7; m0_rready_i = 1; #1;
    chk("rd_m0_rvalid", m0_rvalid_o, 1);
    chk("rd_m0_rdata", m0_rdata_o, DATA);
    chk("rd_m0_rid", m0_rid_o, 4'h2);
    chk("rd_m1_rvalid", m1_rvalid_o, 0);
    tick();
    {s_rvalid_i, s_rlast_i, m0_rready_i} = '0;

    // Simultaneous reads after reset: m0 first, then m1
    rst_ni = 0; tick(); rst_ni = 1;
    m0_arvalid_i = 1; m0_arid_i = 4'h3; m1_arvalid_i = 1; m1_arid_i = 4'h5; #1;
    chk("sim_m0_arready", m0_arready_o, 1);
    chk("sim_m1_arready", m1_arready_o, 0);
    tick();
    m0_arvalid_i = 0; #1;
    chk("sim_s_arid_m0", s_arid_o, 4'h3);
    chk("sim_m1_wait", m1_arready_o, 0);
    ar_accept();
    r_done(1'b0, DATA);
    #1;
    chk("sim_m1_arready", m1_arready_o, 1);
    tick();
    m1_arvalid_i = 0; #1;
    chk("sim_s_arid_m1", s_arid_o, 4'hD);
    ar_accept();
    s_rvalid_i = 1; s_rlast_i = 1; m1_rready_i = 1; #1;
    chk("sim_m1_rvalid", m1_rvalid_o, 1);
    chk("sim_m0_rvalid", m0_rvalid_o, 0);
    chk("sim_m1_rid", m1_rid_o, 4'h5);
    tick();
    {s_rvalid_i, s_rlast_i, m1_rready_i} = '0;

    // Same master AW and AR together: AW first
    m1_awvalid_i = 1; m1_awid_i = 4'h1; m1_awaddr_i = 32'h2000;
    m1_arvalid_i = 1; m1_arid_i = 4'h6; m1_araddr_i = 32'h3000; #1;
    chk("aa_m1_awready", m1_awready_o, 1);
    chk("aa_m1_arready", m1_arready_o, 0);
    tick();
    m1_awvalid_i = 0; #1;
    chk("aa_s_awid", s_awid_o, 4'h9);
    chk("aa_s_arvalid", s_arvalid_o, 0);
    aw_accept();
    w_beat(1'b1, DATA);
    #1;
    chk("aa_in_b_arready", m1_arready_o, 0);
    b_done(1'b1);
    #1;
    chk("aa_after_b_arready", m1_arready_o, 1);
    tick();
    m1_arvalid_i = 0; #1;
    chk("aa_s_araddr", s_araddr_o, 32'h3000);
    ar_accept();
    r_done(1'b1, DATA);

    // Backpressure on AW and B while m1 waits
    m0_awvalid_i = 1; m0_awaddr_i = 32'h4000; m0_awid_i = 4'h3;
    m1_arvalid_i = 1; m1_arid_i = 4'h2; #1;
    chk("bp_m0_awready", m0_awready_o, 1);
    tick();
    m0_awvalid_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_s_awvalid", s_awvalid_o, 1);
      chk("bp_s_awaddr", s_awaddr_o, 32'h4000);
      chk("bp_m1_arready", m1_arready_o, 0);
    end
    aw_accept();
    w_beat(1'b0, DATA);
    s_bvalid_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_m0_bvalid", m0_bvalid_o, 1);
      chk("bp_s_bready", s_bready_o, 0);
      chk("bp_m1_arready_b", m1_arready_o, 0);
      tick();
    end
    m0_bready_i = 1;
    tick();
    {s_bvalid_i, m0_bready_i} = '0;
    #1;
    chk("bp_m1_granted", m1_arready_o, 1);
    tick();
    m1_arvalid_i = 0;
    ar_accept();
    r_done(1'b1, DATA);

    // Starvation: 8 back-to-back reads from each master must alternate
    c0 = 0; c1 = 0;
    m0_arid_i = 4'h1; m1_arid_i = 4'h1;
    for (int k = 0; k < 16; k++) begin
      exp_m1 = k[0];
      m0_arvalid_i = (c0 < 8); m1_arvalid_i = (c1 < 8); #1;
      chk("st_m0_arready", m0_arready_o, !exp_m1);
      chk("st_m1_arready", m1_arready_o, exp_m1);
      tick();
      chk("st_s_arid_gnt", s_arid_o[IW-1], exp_m1);
      if (exp_m1) c1++; else c0++;
      {m0_arvalid_i, m1_arvalid_i} = '0;
      ar_accept();
      r_done(exp_m1, DATA);
    end

    // Reset during W, then a fresh m1 write
    m1_awvalid_i = 1; m1_awaddr_i = 32'h5000; m1_awid_i = 4'h4; #1;
    chk("rw_m1_awready", m1_awready_o, 1);
    tick();
    m1_awvalid_i = 0;
    aw_accept();
    m1_wvalid_i = 1; m1_wlast_i = 0; m1_wdata_i = DATA; s_wready_i = 1; #1;
    chk("rw_m1_wready", m1_wready_o, 1);
    rst_ni = 0;
    tick();
    rst_ni = 1; {m1_wvalid_i, s_wready_i} = '0; #1;
    chk("rw_s_wvalid", s_wvalid_o, 0);
    chk("rw_s_wdata", s_wdata_o, 0);
    chk("rw_s_awvalid", s_awvalid_o, 0);
    chk("rw_s_awaddr", s_awaddr_o, 0);
    chk("rw_s_awid", s_awid_o, 0);
    chk("rw_m1_bvalid", m1_bvalid_o, 0);
    m1_awvalid_i = 1; m1_awaddr_i = 32'h6000; m1_awid_i = 4'h7; #1;
    chk("rw2_m1_awready", m1_awready_o, 1);
    tick();
    m1_awvalid_i = 0; #1;
    chk("rw2_s_awid", s_awid_o, 4'hF);
    chk("rw2_s_awaddr", s_awaddr_o, 32'h6000);
    aw_accept();
    w_beat(1'b1, DATA);
    s_bvalid_i = 1; m1_bready_i = 1; #1;
    chk("rw2_m1_bvalid", m1_bvalid_o, 1);
    chk("rw2_m1_bid", m1_bid_o, 4'h7);
    tick();
    {s_bvalid_i, m1_bready_i} = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
